// File: rtl/lcd_refresh_seq.sv
// lcd_refresh_seq
//   Frame-refresh sequencer for the EADOGS102N-6 LCD. Walks the frame-buffer
//   RAM page by page and presents, per page, the page-address command, the
//   two column-address commands and then every column byte of that page to
//   the SPI byte engine over a valid/ready handshake.
//
// Ports
//   i_sysclk    system clock
//   i_sysrst    asynchronous active-high reset
//   i_start     one-cycle frame start pulse (ignored while busy)
//   i_abort     level; stops the refresh at the next byte boundary
//   o_busy      refresh in progress
//   o_done      one-cycle pulse after the last byte of a complete frame
//   o_fb_rd     frame-buffer read strobe
//   o_fb_addr   frame-buffer address (page*C_COLS + col)
//   i_fb_data   frame-buffer read data, one cycle after o_fb_rd
//   o_tx_valid  byte valid toward the SPI engine
//   o_tx_byte   byte to transmit
//   o_tx_cd     0 = command, 1 = display data
//   i_tx_ready  SPI engine accepts the byte when high together with o_tx_valid
module lcd_refresh_seq #(
    parameter int C_PAGES      = 8,
    parameter int C_COLS       = 102,
    parameter int C_COL_OFFSET = 0
) (
    input  logic       i_sysclk,
    input  logic       i_sysrst,
    input  logic       i_start,
    input  logic       i_abort,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_fb_rd,
    output logic [9:0] o_fb_addr,
    input  logic [7:0] i_fb_data,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_byte,
    output logic       o_tx_cd,
    input  logic       i_tx_ready
);

    localparam int CW = (C_COLS  > 1) ? $clog2(C_COLS)  : 1;
    localparam int PW = (C_PAGES > 1) ? $clog2(C_PAGES) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(C_COLS - 1);
    localparam logic [PW-1:0] PAGE_LAST = PW'(C_PAGES - 1);
    localparam logic [7:0]    OFF8      = 8'(C_COL_OFFSET);
    localparam logic [7:0]    COLH_BYTE = 8'h10 | {4'h0, OFF8[7:4]};
    localparam logic [7:0]    COLL_BYTE = {4'h0, OFF8[3:0]};

    typedef enum logic [2:0] {
        IDLE,
        CMD_PAGE,
        CMD_COLH,
        CMD_COLL,
        FETCH,
        LATCH,
        DATA,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] page_q, page_d;
    logic [CW-1:0] col_q, col_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fb_rd_q, fb_rd_d;
    logic [9:0]    fb_addr_q, fb_addr_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          tx_cd_q, tx_cd_d;

    logic          hs;
    logic          abort_now;

    assign hs = tx_valid_q & i_tx_ready;

    function automatic logic [7:0] page_cmd(input logic [PW-1:0] p);
        logic [3:0] nib;
        nib = 4'(p);
        return 8'hB0 | {4'h0, nib};
    endfunction

    // Outputs are registered, so every handshake preloads the byte of the
    // state being entered; otherwise a held-high ready would accept the old
    // byte twice.
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        col_d      = col_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fb_rd_d    = 1'b0;
        fb_addr_d  = fb_addr_q;
        tx_valid_d = tx_valid_q;
        tx_byte_d  = tx_byte_q;
        tx_cd_d    = tx_cd_q;
        abort_now  = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d     = 1'b0;
                tx_valid_d = 1'b0;
                if (i_start) begin
                    page_d    = '0;
                    col_d     = '0;
                    fb_addr_d = '0;
                    state_d   = CMD_PAGE;
                end
            end
            CMD_PAGE: begin
                busy_d     = 1'b1;
                tx_valid_d = 1'b1;
                tx_cd_d    = 1'b0;
                if (hs) begin
                    abort_now = i_abort;
                    tx_byte_d = COLH_BYTE;
                    state_d   = CMD_COLH;
                end else begin
                    // first entry from IDLE arrives with valid still low
                    tx_byte_d = page_cmd(page_q);
                end
            end
            CMD_COLH: begin
                if (hs) begin
                    abort_now = i_abort;
                    tx_byte_d = COLL_BYTE;
                    state_d   = CMD_COLL;
                end
            end
            CMD_COLL: begin
                if (hs) begin
                    abort_now  = i_abort;
                    tx_valid_d = 1'b0;
                    fb_rd_d    = 1'b1;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                abort_now = i_abort;
                state_d   = LATCH;
            end
            LATCH: begin
                abort_now  = i_abort;
                tx_byte_d  = i_fb_data;
                tx_cd_d    = 1'b1;
                tx_valid_d = 1'b1;
                state_d    = DATA;
            end
            DATA: begin
                if (hs) begin
                    abort_now = i_abort;
                    if (col_q < COL_LAST) begin
                        col_d      = col_q + CW'(1);
                        fb_addr_d  = fb_addr_q + 10'd1;
                        tx_valid_d = 1'b0;
                        fb_rd_d    = 1'b1;
                        state_d    = FETCH;
                    end else if (page_q < PAGE_LAST) begin
                        // page*C_COLS + C_COLS equals the next page's base
                        col_d      = '0;
                        page_d     = page_q + PW'(1);
                        fb_addr_d  = fb_addr_q + 10'd1;
                        tx_valid_d = 1'b1;
                        tx_cd_d    = 1'b0;
                        tx_byte_d  = page_cmd(page_q + PW'(1));
                        state_d    = CMD_PAGE;
                    end else begin
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_now) begin
            state_d    = IDLE;
            page_d     = '0;
            col_d      = '0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            fb_rd_d    = 1'b0;
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_sysclk or posedge i_sysrst) begin
        if (i_sysrst) begin
            state_q    <= IDLE;
            page_q     <= '0;
            col_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fb_rd_q    <= 1'b0;
            fb_addr_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_byte_q  <= '0;
            tx_cd_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            col_q      <= col_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fb_rd_q    <= fb_rd_d;
            fb_addr_q  <= fb_addr_d;
            tx_valid_q <= tx_valid_d;
            tx_byte_q  <= tx_byte_d;
            tx_cd_q    <= tx_cd_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_fb_rd    = fb_rd_q;
    assign o_fb_addr  = fb_addr_q;
    assign o_tx_valid = tx_valid_q;
    assign o_tx_byte  = tx_byte_q;
    assign o_tx_cd    = tx_cd_q;

endmodule

// File: tb/tb_lcd_refresh_seq.sv
// Testbench for lcd_refresh_seq: default instance plus a column-offset-30
// instance sharing the same controls, each with its own frame-buffer RAM.
module tb_lcd_refresh_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ready = 1'b1;

    logic       busy, done, fb_rd, valid, cd;
    logic [9:0] fb_addr;
    logic [7:0] fb_data = 8'h00;
    logic [7:0] tx_byte;

    logic       busy2, done2, fb_rd2, valid2, cd2;
    logic [9:0] fb_addr2;
    logic [7:0] fb_data2 = 8'h00;
    logic [7:0] tx_byte2;

    int n_checks = 0;
    int n_fail   = 0;

    // monitor-owned observations
    int cyc = 0;
    int busy_rise_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int done2_cnt = 0;
    int stab_err = 0;
    logic busy_prev = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic prev_cd = 1'b0;
    logic [8:0] q[$];
    logic [8:0] q2[$];

    // stimulus-owned ready generator state
    int mode = 0;
    int low_left = 0;

    always #5 clk = ~clk;

    lcd_refresh_seq dut (
        .i_sysclk(clk), .i_sysrst(rst), .i_start(start), .i_abort(abort),
        .o_busy(busy), .o_done(done), .o_fb_rd(fb_rd), .o_fb_addr(fb_addr),
        .i_fb_data(fb_data), .o_tx_valid(valid), .o_tx_byte(tx_byte),
        .o_tx_cd(cd), .i_tx_ready(ready)
    );

    lcd_refresh_seq #(.C_PAGES(8), .C_COLS(102), .C_COL_OFFSET(30)) dut_off (
        .i_sysclk(clk), .i_sysrst(rst), .i_start(start), .i_abort(abort),
        .o_busy(busy2), .o_done(done2), .o_fb_rd(fb_rd2), .o_fb_addr(fb_addr2),
        .i_fb_data(fb_data2), .o_tx_valid(valid2), .o_tx_byte(tx_byte2),
        .o_tx_cd(cd2), .i_tx_ready(ready)
    );

    function automatic logic [7:0] fbval(input int a);
        return 8'((a * 37 + 11) ^ (a >> 3));
    endfunction

    // expected {cd, byte} of the k-th byte of a frame
    function automatic logic [8:0] exp_byte(input int k, input int off);
        int p;
        int r;
        p = k / 105;
        r = k % 105;
        if (r == 0) return {1'b0, 8'hB0 | 8'(p)};
        if (r == 1) return {1'b0, 8'h10 | 8'(off >> 4)};
        if (r == 2) return {1'b0, 8'(off & 15)};
        return {1'b1, fbval(p * 102 + r - 3)};
    endfunction

    always @(posedge clk) begin
        if (fb_rd)  fb_data  <= fbval(int'(fb_addr));
        if (fb_rd2) fb_data2 <= fbval(int'(fb_addr2));
    end

    always @(negedge clk) begin
        cyc++;
        if (busy && !busy_prev) busy_rise_cyc = cyc;
        busy_prev = busy;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (done2) done2_cnt++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!valid || tx_byte != prev_byte || cd != prev_cd)) stab_err++;
            if (valid && ready)  q.push_back({cd, tx_byte});
            if (valid2 && ready) q2.push_back({cd2, tx_byte2});
            prev_stall = valid && !ready;
            prev_byte  = tx_byte;
            prev_cd    = cd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (mode)
            0: ready = 1'b1;
            1: begin
                if (low_left > 0) begin
                    ready = 1'b0;
                    low_left--;
                end else if ($urandom_range(0, 7) == 0) begin
                    low_left = $urandom_range(3, 25);
                    ready = 1'b0;
                end else begin
                    ready = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int base_done, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (done_cnt != base_done) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        n_checks += 7;
        if (valid   !== 1'b0)  begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid); end
        if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte got %h exp 00", tx_byte); end
        if (cd      !== 1'b0)  begin n_fail++; $display("FAIL reset_cd got %b exp 0", cd); end
        if (busy    !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        if (done    !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        if (fb_rd   !== 1'b0)  begin n_fail++; $display("FAIL reset_fb_rd got %b exp 0", fb_rd); end
        if (fb_addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", fb_addr); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_full_frame();
        int base;
        int bd;
        int bd2;
        bit ok;
        mode = 0;
        base = q.size();
        bd = done_cnt;
        bd2 = done2_cnt;
        pulse_start();
        n_checks += 2;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL first_valid_early got %b exp 0", valid); end
        if (busy  !== 1'b0) begin n_fail++; $display("FAIL busy_early got %b exp 0", busy); end
        tick();
        n_checks += 3;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b exp 1", valid); end
        if ({cd, tx_byte} !== 9'h0B0) begin n_fail++; $display("FAIL first_byte got %h exp 0b0", {cd, tx_byte}); end
        if (busy  !== 1'b1) begin n_fail++; $display("FAIL busy_rise got %b exp 1", busy); end
        wait_done(bd, 6000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL full_timeout got no done exp done"); end
        repeat (10) tick();
        n_checks += 5;
        if (q.size() - base != 840) begin n_fail++; $display("FAIL full_count got %0d exp 840", q.size() - base); end
        if (done_cnt - bd != 1) begin n_fail++; $display("FAIL full_done_pulses got %0d exp 1", done_cnt - bd); end
        if (done_cyc - busy_rise_cyc != 2472) begin n_fail++; $display("FAIL full_cycles got %0d exp 2472", done_cyc - busy_rise_cyc); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_end got %b exp 0", busy); end
        if (done2_cnt - bd2 != 1) begin n_fail++; $display("FAIL off_done_pulses got %0d exp 1", done2_cnt - bd2); end
        if (q.size() - base >= 840) begin
            for (int i = 0; i < 840; i++) begin
                n_checks++;
                if (q[base + i] !== exp_byte(i, 0)) begin
                    n_fail++;
                    $display("FAIL full_stream[%0d] got %h exp %h", i, q[base + i], exp_byte(i, 0));
                end
            end
        end
        n_checks++;
        if (q2.size() - base != 840) begin n_fail++; $display("FAIL off_count got %0d exp 840", q2.size() - base); end
        if (q2.size() - base >= 840) begin
            for (int p = 0; p < 8; p++) begin
                for (int r = 0; r < 3; r++) begin
                    n_checks++;
                    if (q2[base + p * 105 + r] !== exp_byte(p * 105 + r, 30)) begin
                        n_fail++;
                        $display("FAIL off_cmd[p%0d,%0d] got %h exp %h", p, r, q2[base + p * 105 + r], exp_byte(p * 105 + r, 30));
                    end
                end
            end
        end
    endtask

    task automatic test_stall();
        int base;
        int bd;
        int se;
        bit ok;
        base = q.size();
        bd = done_cnt;
        se = stab_err;
        mode = 1;
        pulse_start();
        wait_done(bd, 30000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stall_timeout got no done exp done"); end
        mode = 0;
        repeat (10) tick();
        n_checks += 3;
        if (stab_err != se) begin n_fail++; $display("FAIL stall_stability got %0d changes exp 0", stab_err - se); end
        if (q.size() - base != 840) begin n_fail++; $display("FAIL stall_count got %0d exp 840", q.size() - base); end
        if (done_cnt - bd != 1) begin n_fail++; $display("FAIL stall_done_pulses got %0d exp 1", done_cnt - bd); end
        if (q.size() - base >= 840) begin
            for (int i = 0; i < 840; i++) begin
                n_checks++;
                if (q[base + i] !== exp_byte(i, 0)) begin
                    n_fail++;
                    $display("FAIL stall_stream[%0d] got %h exp %h", i, q[base + i], exp_byte(i, 0));
                end
            end
        end
    endtask

    task automatic test_restart_ignored();
        int base;
        int bd;
        bit ok;
        bit hit;
        mode = 0;
        base = q.size();
        bd = done_cnt;
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            tick();
            if (q.size() - base >= 3 * 105 + 10) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL restart_reach_page3 got timeout exp page 3"); end
        pulse_start();
        wait_done(bd, 6000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL restart_timeout got no done exp done"); end
        repeat (20) tick();
        n_checks += 2;
        if (q.size() - base != 840) begin n_fail++; $display("FAIL restart_count got %0d exp 840", q.size() - base); end
        if (done_cnt - bd != 1) begin n_fail++; $display("FAIL restart_done_pulses got %0d exp 1", done_cnt - bd); end
        if (q.size() - base >= 840) begin
            for (int i = 0; i < 840; i++) begin
                n_checks++;
                if (q[base + i] !== exp_byte(i, 0)) begin
                    n_fail++;
                    $display("FAIL restart_stream[%0d] got %h exp %h", i, q[base + i], exp_byte(i, 0));
                end
            end
        end
    endtask

    task automatic test_abort();
        int base;
        int bd;
        bit hit;
        bit ok;
        mode = 0;
        base = q.size();
        bd = done_cnt;
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            tick();
            if (q.size() - base == 263 && !valid) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL abort_reach got timeout exp page2 col50"); end
        mode = 2;
        ready = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            tick();
            if (valid) hit = 1'b1;
        end
        abort = 1'b1;
        repeat (3) tick();
        n_checks += 3;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL abort_hold_valid got %b exp 1", valid); end
        if ({cd, tx_byte} !== exp_byte(263, 0)) begin n_fail++; $display("FAIL abort_hold_byte got %h exp %h", {cd, tx_byte}, exp_byte(263, 0)); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_hold_busy got %b exp 1", busy); end
        ready = 1'b1;
        tick();
        n_checks += 3;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid_after got %b exp 0", valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after got %b exp 0", busy); end
        if (q.size() - base != 264) begin n_fail++; $display("FAIL abort_count got %0d exp 264", q.size() - base); end
        abort = 1'b0;
        mode = 0;
        repeat (20) tick();
        n_checks += 2;
        if (done_cnt != bd) begin n_fail++; $display("FAIL abort_no_done got %0d exp 0", done_cnt - bd); end
        if (q.size() - base != 264) begin n_fail++; $display("FAIL abort_idle_count got %0d exp 264", q.size() - base); end
        base = q.size();
        pulse_start();
        tick();
        n_checks++;
        if ({valid, cd, tx_byte} !== 10'h0B0 + 10'h200) begin n_fail++; $display("FAIL abort_restart_first got %b/%h exp 1/0b0", valid, {cd, tx_byte}); end
        wait_done(bd, 6000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL abort_restart_timeout got no done exp done"); end
        repeat (10) tick();
        n_checks++;
        if (q.size() - base != 840) begin n_fail++; $display("FAIL abort_restart_count got %0d exp 840", q.size() - base); end
        if (q.size() - base >= 840) begin
            for (int i = 0; i < 840; i++) begin
                n_checks++;
                if (q[base + i] !== exp_byte(i, 0)) begin
                    n_fail++;
                    $display("FAIL abort_restart_stream[%0d] got %h exp %h", i, q[base + i], exp_byte(i, 0));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int base;
        int bd;
        bit hit;
        bit ok;
        mode = 0;
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            tick();
            if (valid && cd && busy) hit = 1'b1;
        end
        mode = 2;
        ready = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (!(valid && cd)) begin n_fail++; $display("FAIL rst_stall_setup got valid=%b cd=%b exp 1/1", valid, cd); end
        #1;
        rst = 1'b1;
        #1;
        n_checks += 7;
        if (valid   !== 1'b0)  begin n_fail++; $display("FAIL arst_valid got %b exp 0", valid); end
        if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL arst_byte got %h exp 00", tx_byte); end
        if (cd      !== 1'b0)  begin n_fail++; $display("FAIL arst_cd got %b exp 0", cd); end
        if (busy    !== 1'b0)  begin n_fail++; $display("FAIL arst_busy got %b exp 0", busy); end
        if (done    !== 1'b0)  begin n_fail++; $display("FAIL arst_done got %b exp 0", done); end
        if (fb_rd   !== 1'b0)  begin n_fail++; $display("FAIL arst_fb_rd got %b exp 0", fb_rd); end
        if (fb_addr !== 10'd0) begin n_fail++; $display("FAIL arst_addr got %0d exp 0", fb_addr); end
        tick();
        tick();
        rst = 1'b0;
        mode = 0;
        tick();
        base = q.size();
        bd = done_cnt;
        pulse_start();
        wait_done(bd, 6000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL arst_restart_timeout got no done exp done"); end
        repeat (10) tick();
        n_checks += 2;
        if (q.size() - base != 840) begin n_fail++; $display("FAIL arst_count got %0d exp 840", q.size() - base); end
        if (done_cnt - bd != 1) begin n_fail++; $display("FAIL arst_done_pulses got %0d exp 1", done_cnt - bd); end
        if (q.size() - base >= 840) begin
            for (int i = 0; i < 840; i++) begin
                n_checks++;
                if (q[base + i] !== exp_byte(i, 0)) begin
                    n_fail++;
                    $display("FAIL arst_stream[%0d] got %h exp %h", i, q[base + i], exp_byte(i, 0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_stall();
        test_restart_ignored();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_refresh_seq.md
# lcd_refresh_seq

Frame-refresh sequencer for the EADOGS102N-6 LCD. It walks a frame-buffer RAM page by page and feeds the SPI byte engine one byte at a time over a valid/ready handshake. For each page it sends the page-address and column-address commands, then every column byte of that page. It sits between the frame-buffer RAM and the SPI byte transmitter, so the CPU only has to issue one start pulse per frame.

## Interface
Parameters:
- C_PAGES, 8, number of LCD pages (8 pixel rows each)
- C_COLS, 102, columns per page; C_PAGES*C_COLS must be ≤ 1024
- C_COL_OFFSET, 0, column offset (0 or 30) programmed into the column-address commands

Ports:
- i_sysclk  in  1  system clock; the only clock
- i_sysrst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle pulse that starts a frame refresh; ignored while o_busy=1
- i_abort  in  1  level; stops the refresh at the next byte boundary
- o_busy  out  1  high from the cycle after an accepted start until the return to IDLE
- o_done  out  1  one-cycle pulse when a full frame has been sent; not asserted after an abort
- o_fb_rd  out  1  frame-buffer read strobe
- o_fb_addr  out  10  frame-buffer address = page*C_COLS + col
- i_fb_data  in  8  frame-buffer read data, valid exactly 1 cycle after o_fb_rd
- o_tx_valid  out  1  byte valid toward the SPI engine
- o_tx_byte  out  8  byte to transmit
- o_tx_cd  out  1  0 = command byte, 1 = display-data byte (drives the LCD CD line)
- i_tx_ready  in  1  SPI engine can accept a byte; a byte transfers when o_tx_valid & i_tx_ready

## Operation
- All outputs are registered. Reset values: every output is 0. Internal state is IDLE, with page=0 and col=0.
- States: IDLE, CMD_PAGE, CMD_COLH, CMD_COLL, FETCH, LATCH, DATA, DONE.
- IDLE: when i_start=1, clear page and col and go to CMD_PAGE.
- CMD_PAGE:
  - o_tx_byte = 0xB0 | page[3:0], o_tx_cd = 0, o_tx_valid = 1.
  - On handshake, go to CMD_COLH.
- CMD_COLH:
  - o_tx_byte = 0x10 | C_COL_OFFSET[7:4], o_tx_cd = 0.
  - On handshake, go to CMD_COLL.
- CMD_COLL:
  - o_tx_byte = 0x00 | C_COL_OFFSET[3:0], o_tx_cd = 0.
  - On handshake, go to FETCH.
- FETCH: o_tx_valid = 0, o_fb_rd = 1, o_fb_addr = page*C_COLS + col. Go to LATCH.
- LATCH: o_fb_rd = 0. Register i_fb_data into o_tx_byte, set o_tx_cd = 1 and o_tx_valid = 1. Go to DATA.
- DATA: hold o_tx_byte, o_tx_cd and o_tx_valid. On handshake:
  - If col < C_COLS-1: col += 1, go to FETCH.
  - Else if page < C_PAGES-1: col = 0, page += 1, go to CMD_PAGE.
  - Else: go to DONE.
- DONE: pulse o_done for one cycle, clear o_busy, go to IDLE.
- Handshake rule: once o_tx_valid=1, o_tx_byte and o_tx_cd stay stable, and o_tx_valid stays high, until the handshake occurs. o_tx_valid never drops without a handshake.
- Abort:
  - Sampled when a handshake occurs, and in FETCH/LATCH.
  - If i_abort=1, go to IDLE. No o_done pulse. page and col are cleared.
  - An abort while o_tx_valid=1 without ready waits for the handshake to complete.
- A start pulse while busy is ignored and is not queued.
- Asynchronous reset at any point forces IDLE and all outputs to 0 immediately. A partially presented byte is dropped.
- col and page counters are exact width (7 and 3 bits for the defaults). Arithmetic never wraps inside a frame because the terminal compares use C_COLS-1 and C_PAGES-1.

## Timing
- Start to first o_tx_valid: i_start is sampled at edge N, and o_tx_valid=1 with byte 0xB0 appears after edge N+1. o_busy rises at the same time.
- With i_tx_ready held at 1:
  - Each command byte takes 1 cycle.
  - Each data byte takes 3 cycles (FETCH, LATCH, DATA).
  - Per page: 3 + 3*C_COLS cycles. Default frame: 8*(3+306) = 2472 cycles from the first valid to the DONE state.
- Read latency is fixed at 1 cycle. o_fb_addr stays stable from FETCH through DATA.
- o_done is asserted for exactly 1 cycle, in the cycle after the last data handshake.

## Test plan
- Default parameters, ready tied to 1, one start pulse:
  - Exactly 840 bytes are sent.
  - Page 0 begins with 0xB0, 0x10, 0x00 (cd=0), followed by fb[0..101] (cd=1).
  - Page 7 begins with 0xB7 and covers addresses 714..815.
  - o_done pulses once, 2472 cycles after the first valid.
- C_COL_OFFSET=30: every page's column commands are 0x11 then 0x0E.
- i_tx_ready toggled pseudo-randomly with long low stretches: o_tx_byte and o_tx_cd never change while valid and not ready, and the byte sequence matches the ready-high run.
- i_start pulsed again mid-frame (page 3): no restart, the byte count is still 840, and only one o_done pulse occurs.
- i_abort asserted during page 2 column 50:
  - The current byte completes its handshake.
  - The block returns to IDLE with no o_done.
  - A following start sends 0xB0 first.
- Asynchronous i_sysrst asserted mid-cycle during a DATA stall: all outputs go to 0 before the next clock edge, and after release a start produces a clean full frame.
